// File: rtl/acc_channel_scheduler.sv
// rtl/acc_channel_scheduler.sv - one adder time-multiplexed over NUM_CH accumulator channels
module acc_channel_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int ACC_WIDTH = 16,
  parameter int ADD_WIDTH = 16,
  localparam int CH_W     = $clog2(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 cfg_we,
  input  logic [CH_W-1:0]      cfg_ch,
  input  logic [ADD_WIDTH-1:0] cfg_step,
  input  logic                 cfg_en,
  input  logic                 cfg_clr,
  input  logic                 overrun_clr,
  input  logic [CH_W-1:0]      rd_ch,
  output logic [ACC_WIDTH-1:0] rd_data,
  output logic                 busy,
  output logic                 out_valid,
  output logic [CH_W-1:0]      out_ch,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 overrun
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state, state_next;
  logic [CH_W-1:0]        idx;
  logic [ACC_WIDTH-1:0]   acc  [NUM_CH];
  logic [ADD_WIDTH-1:0]   step [NUM_CH];
  logic [NUM_CH-1:0]      en;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   last_slot;
  logic                   clr_hit;

  assign rd_data = acc[rd_ch];

  always_comb begin
    state_next = state;
    busy       = (state == RUN);
    last_slot  = (idx == CH_W'(NUM_CH - 1));
    sum        = acc[idx] + ACC_WIDTH'(step[idx]);
    clr_hit    = cfg_we && cfg_clr && (cfg_ch == idx);
    case (state)
      IDLE: if (tick) state_next = RUN;
      RUN:  if (last_slot) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      en        <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      overrun   <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        acc[i]  <= '0;
        step[i] <= '0;
      end
    end else begin
      state     <= state_next;
      out_valid <= 1'b0;
      if (state == RUN) begin
        // idx wraps back to 0 after the last slot since NUM_CH is a power of two
        idx <= idx + 1'b1;
        if (en[idx]) begin
          acc[idx]  <= sum;
          out_valid <= 1'b1;
          out_ch    <= idx;
          out_data  <= clr_hit ? '0 : sum;
        end
      end else begin
        idx <= '0;
      end
      // A same-edge config write lands after the add, so a clear beats it
      if (cfg_we) begin
        step[cfg_ch] <= cfg_step;
        en[cfg_ch]   <= cfg_en;
        if (cfg_clr) acc[cfg_ch] <= '0;
      end
      if (tick && state == RUN) overrun <= 1'b1;
      else if (overrun_clr)     overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_channel_scheduler.sv
// tb/tb_acc_channel_scheduler.sv - scoreboard bench for acc_channel_scheduler
module tb_acc_channel_scheduler;
  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tick = 1'b0;
  logic        cfg_we = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [15:0] cfg_step = '0;
  logic        cfg_en = 1'b0;
  logic        cfg_clr = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [1:0]  rd_ch = '0;
  logic [15:0] rd_data;
  logic        busy;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [15:0] out_data;
  logic        overrun;

  acc_channel_scheduler #(.NUM_CH(NCH), .ACC_WIDTH(16), .ADD_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_step(cfg_step), .cfg_en(cfg_en), .cfg_clr(cfg_clr),
    .overrun_clr(overrun_clr), .rd_ch(rd_ch), .rd_data(rd_data), .busy(busy),
    .out_valid(out_valid), .out_ch(out_ch), .out_data(out_data), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; int ch; int data;} exp_t;
  exp_t q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  // Reference model: per-channel state plus the position within the current sweep
  int m_acc [NCH];
  int m_step[NCH];
  bit m_en  [NCH];
  bit m_run;
  int m_slot;
  bit m_ovr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NCH; i++) begin
      m_acc[i] = 0; m_step[i] = 0; m_en[i] = 0;
    end
    m_run = 0; m_slot = 0; m_ovr = 0;
  endtask

  task automatic rd_check(input int ch, input int exp);
    rd_ch = ch[1:0];
    #1;
    check($sformatf("rd_data ch%0d", ch), int'(rd_data), exp);
  endtask

  task automatic cyc_step(input bit t, input bit we, input int ch, input int stp,
                          input bit e, input bit clr, input bit oclr);
    bit ovr_set;
    int c, nv;
    tick = t; cfg_we = we; cfg_ch = ch[1:0]; cfg_step = stp[15:0];
    cfg_en = e; cfg_clr = clr; overrun_clr = oclr;
    @(posedge clk);
    cyc++;
    ovr_set = t && m_run;
    if (m_run) begin
      c = m_slot;
      if (m_en[c]) begin
        nv = (m_acc[c] + m_step[c]) % 65536;
        if (we && clr && ch == c) nv = 0;
        q.push_back('{cyc, c, nv});
        m_acc[c] = nv;
      end
      m_slot++;
      if (m_slot == NCH) m_run = 0;
    end else if (t) begin
      m_run = 1; m_slot = 0;
    end
    if (we) begin
      m_step[ch] = stp % 65536;
      m_en[ch]   = e;
      if (clr) m_acc[ch] = 0;
    end
    if (ovr_set) m_ovr = 1;
    else if (oclr) m_ovr = 0;
    #1;
    tick = 0; cfg_we = 0; cfg_clr = 0; overrun_clr = 0;
    c = $urandom_range(0, NCH - 1);
    rd_ch = c[1:0];
    #1;
    check("rd_data", int'(rd_data), m_acc[c]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic cfg(input int ch, input int stp, input bit e, input bit clr);
    cyc_step(0, 1, ch, stp, e, clr, 0);
  endtask

  task automatic do_reset();
    rst_n = 0; tick = 0; cfg_we = 0; cfg_clr = 0; overrun_clr = 0;
    @(posedge clk);
    cyc++;
    model_clear();
    q.delete();
    #1;
    rst_n = 1;
    check("rst out_valid", int'(out_valid), 0);
    check("rst out_ch", int'(out_ch), 0);
    check("rst out_data", int'(out_data), 0);
    check("rst busy", int'(busy), 0);
    check("rst overrun", int'(overrun), 0);
    for (int i = 0; i < NCH; i++) rd_check(i, 0);
    mon_on = 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_on && rst_n) begin
      check("busy", int'(busy), int'(m_run));
      check("overrun", int'(overrun), int'(m_ovr));
      if (out_valid) begin
        if (q.size() == 0 || q[0].cyc != cyc) begin
          check("out_valid unexpected", 1, 0);
        end else begin
          e = q.pop_front();
          check("out_ch", int'(out_ch), e.ch);
          check("out_data", int'(out_data), e.data);
        end
      end else if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        check($sformatf("out_valid missing ch%0d", e.ch), 0, 1);
      end
    end
  end

  initial begin
    int busy_cnt, keep1, t0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // all channels enabled, step k+1, one sweep
    for (int k = 0; k < NCH; k++) cfg(k, k + 1, 1, 0);
    busy_cnt = 0;
    cyc_step(1, 0, 0, 0, 0, 0, 0);
    if (busy) busy_cnt++;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (busy) busy_cnt++;
    end
    check("busy cycles", busy_cnt, NCH);
    for (int k = 0; k < NCH; k++) rd_check(k, k + 1);

    // wrap: acc[2] -> 0xFFFE, then +3
    cfg(2, 16'hFFFE, 1, 1);
    cyc_step(1, 0, 0, 0, 0, 0, 0); idle(5);
    rd_check(2, 16'hFFFE);
    cfg(2, 3, 1, 0);
    cyc_step(1, 0, 0, 0, 0, 0, 0); idle(5);
    rd_check(2, 1);

    // disabled channel keeps its slot but produces nothing
    cfg(1, 7, 0, 0);
    keep1 = m_acc[1];
    cyc_step(1, 0, 0, 0, 0, 0, 0); idle(5);
    rd_check(1, keep1);

    // overrun: second tick 2 cycles in, clear, then tick at NUM_CH+1
    cyc_step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc_step(1, 0, 0, 0, 0, 0, 0);
    check("overrun set", int'(overrun), 1);
    idle(1);
    check("overrun held", int'(overrun), 1);
    cyc_step(0, 0, 0, 0, 0, 0, 1);
    check("overrun cleared", int'(overrun), 0);
    cyc_step(1, 0, 0, 0, 0, 0, 0);
    check("retick busy", int'(busy), 1);
    idle(5);

    // collision with clear: acc1=10, step 5, clear on its slot
    do_reset();
    cfg(1, 10, 1, 1);
    cyc_step(1, 0, 0, 0, 0, 0, 0); idle(5);
    rd_check(1, 10);
    cfg(1, 5, 1, 0);
    cyc_step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc_step(0, 1, 1, 5, 1, 1, 0);
    rd_check(1, 0);
    idle(3);

    // collision with new step: old step used, new step next sweep
    cfg(1, 10, 1, 0);
    cyc_step(1, 0, 0, 0, 0, 0, 0); idle(5);
    cfg(1, 5, 1, 0);
    cyc_step(1, 0, 0, 0, 0, 0, 0);
    idle(1);
    cyc_step(0, 1, 1, 9, 1, 0, 0);
    rd_check(1, 15);
    idle(3);
    cyc_step(1, 0, 0, 0, 0, 0, 0); idle(5);
    rd_check(1, 24);

    // reset mid-sweep
    for (int k = 0; k < NCH; k++) cfg(k, 100 + k, 1, 0);
    cyc_step(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    do_reset();
    idle(3);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        do_reset();
      end else begin
        cyc_step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 $urandom_range(0, NCH - 1), $urandom_range(0, 65535),
                 $urandom_range(0, 4) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 5) == 0);
      end
    end
    idle(NCH + 2);
    t0 = q.size();
    check("scoreboard drained", t0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/acc_channel_scheduler.md
Name: acc_channel_scheduler

Overview:
- Time-multiplexes one adder across NUM_CH independent accumulator channels, e.g. phase accumulators for multiple voices.
- Each channel has its own accumulator register, step register and enable bit.
- A sample strobe (tick) launches one sweep that processes every channel in index order, one channel per clock.
- Sits between the control/config logic and downstream consumers (waveform/mixer), replacing NUM_CH separate accumulator instances.

Parameters:
- NUM_CH, 4, number of channels (power of two, >=2); CH_W = clog2(NUM_CH).
- ACC_WIDTH, 16, accumulator width per channel.
- ADD_WIDTH, 16, step width (<= ACC_WIDTH), zero-extended before the add.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  reset, synchronous, active-low.
- tick  in  1  one-cycle sweep start strobe.
- cfg_we  in  1  config write strobe.
- cfg_ch  in  CH_W  channel addressed by the config write.
- cfg_step  in  ADD_WIDTH  new step value.
- cfg_en  in  1  new enable bit.
- cfg_clr  in  1  with cfg_we: zero the addressed accumulator.
- overrun_clr  in  1  clears the sticky overrun flag.
- rd_ch  in  CH_W  readback channel select.
- rd_data  out  ACC_WIDTH  combinational accumulator value of rd_ch.
- busy  out  1  high while a sweep is in progress.
- out_valid  out  1  one-cycle strobe: out_ch/out_data carry an updated value.
- out_ch  out  CH_W  channel of the current output.
- out_data  out  ACC_WIDTH  post-update accumulator value.
- overrun  out  1  sticky: a tick arrived while busy.

Behaviour:
- Reset (rst_n low at a clk edge): all acc[], step[] and en[] cleared to 0; FSM to IDLE; idx=0; busy, out_valid, out_ch, out_data and overrun all 0. Reset mid-sweep aborts the sweep; no further outputs.
- FSM states are IDLE and RUN.
- IDLE: tick high at an edge -> RUN, idx=0, busy=1 from the next cycle.
- RUN: at each edge, process channel idx:
  - If en[idx]: acc[idx] <= acc[idx] + step[idx], modulo 2^ACC_WIDTH (wrap, no saturation, no carry out). Register out_valid=1, out_ch=idx, out_data=new value.
  - If !en[idx]: acc unchanged, out_valid=0. The slot is still consumed, so sweep length is fixed at NUM_CH cycles.
  - idx increments. After processing idx=NUM_CH-1 -> IDLE, busy=0 in the following cycle.
- Latency:
  - Tick sampled at edge E0.
  - Channel k is processed at edge E(k+1); its out_valid is high in the cycle after that edge.
  - A back-to-back tick is accepted at the edge following E(NUM_CH), i.e. a minimum tick period of NUM_CH+1 cycles.
- Tick while in RUN: ignored (no queuing); overrun set to 1.
  - overrun_clr clears it.
  - An overrun_clr and a new overrun event in the same cycle leave overrun=1.
- Config write (cfg_we), permitted in any state:
  - step[cfg_ch] <= cfg_step and en[cfg_ch] <= cfg_en at the edge.
  - If cfg_clr, acc[cfg_ch] <= 0.
- Config collision (same edge processes channel cfg_ch):
  - The add uses the old step and old enable.
  - cfg_clr wins over the add: acc=0.
  - If the old enable was 1, out_valid=1 with out_data=0.
  - The new step/enable apply from that channel's next sweep slot.
- out_valid, out_ch and out_data are registered. out_ch and out_data hold their last values when out_valid=0.
- rd_data reflects writes from the previous edge (register read, no bypass).

Test Plan:
- Reset, then en all channels with step[k]=k+1, one tick -> out_valid for 4 consecutive cycles starting 2 cycles after tick, out_ch 0..3, out_data 1,2,3,4; busy high for exactly 4 cycles.
- ACC_WIDTH=16, acc[2] brought to 0xFFFE, step 3, tick -> out_data for ch2 = 0x0001 (wrap).
- en[1]=0, tick -> out_valid pulses only for ch0, ch2, ch3; the ch1 slot stays idle with out_valid=0; acc[1] unchanged on rd_data.
- Tick, then a second tick 2 cycles later -> second tick ignored, overrun=1 and held; overrun_clr -> overrun=0; a tick NUM_CH+1 cycles after the first starts a new sweep.
- cfg_we with cfg_clr=1 to ch1 at the same edge ch1 is processed (acc=10, step=5) -> out_data=0, rd_data(1)=0.
- cfg_we to ch1 with step 9 at the same edge ch1 is processed (acc=10, step=5) -> out_data=15; the next sweep gives 24.
- rst_n low mid-sweep -> all outputs 0 the next cycle, busy=0, rd_data=0 for every channel.
